weight_row_pingpong_buffer: RTL and testbench
=============================================

Name: weight_row_pingpong_buffer

Overview:
- Next-generation weight row buffer for the PE-array row: one double-buffered (ping/pong) banked weight memory per PE array.
- The bus fills the shadow half of each array while the PE array reads the active half.
- Halves swap automatically once the consumer releases the active half and the shadow half is committed.
- Adds full-width bank writes, per-array read enables, read-valid pipeline, ready flags and sticky error reporting.

Parameters:
- BANK_BIT_WIDTH, 64, bits per bank word.
- BANK_DEPTH, 512, words per bank per half; physical depth is 2*BANK_DEPTH.
- BANK_COUNT, 16, banks per row word.
- NUMBER_OF_PE_ARRAYS_PER_ROW, 3, independent ping-pong buffers (N).
- READ_LATENCY, 2, allowed values 1 or 2; cycles from read issue to o_read_data_valid.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- i_write_array_mask  in  N  arrays targeted by a write or commit.
- i_write_en  in  1  write strobe.
- i_write_bank_wen  in  BANK_COUNT  per-bank write enables.
- i_write_addr  in  clog2(BANK_DEPTH)  word address within the shadow half.
- i_write_data  in  BANK_BIT_WIDTH*BANK_COUNT  full row word; bank b = bits [b*W +: W].
- i_write_commit  in  1  pulse; marks shadow halves of masked arrays full.
- o_write_ready  out  N  shadow half of array i is not full.
- i_read_en  in  N  per-array read strobe.
- i_read_addr  in  clog2(BANK_DEPTH) x N (unpacked)  read address within the active half.
- i_read_release  in  N  pulse; consumer finished with the active half.
- o_read_ready  out  N  active half of array i is valid.
- o_read_data_valid  out  N  read data valid.
- o_read_data  out  BANK_BIT_WIDTH*BANK_COUNT x N (unpacked)  read data.
- o_error  out  3  sticky: [0] write to a full shadow, [1] read while not ready, [2] commit while full.
- i_error_clear  in  1  clears o_error.

Behaviour:
- Per-array state: active_sel, active_valid, shadow_full.
- Reset values: active_sel=0, active_valid=0, shadow_full=0, o_read_ready=0, o_write_ready='1, o_read_data_valid=0, o_read_data=0, o_error=0. Memory contents are not reset.
- Write:
  - When i_write_en is high, each masked array i with o_write_ready[i]=1 writes the enabled banks at physical address {~active_sel, i_write_addr}.
  - Masked arrays with o_write_ready[i]=0 drop the write and set o_error[0].
  - A write with wen=0 or mask=0 is a no-op with no error.
- Commit: for masked arrays, i_write_commit sets shadow_full. If shadow_full is already set, set o_error[2] and leave the state unchanged.
- Release: clears active_valid. Release while active_valid=0 is ignored.
- Swap rule, evaluated per edge on post-event values: av' = active_valid & ~release, sf' = shadow_full | commit. If av'=0 and sf'=1, then active_sel toggles, active_valid=1, shadow_full=0.
  - Release and commit in the same cycle, with an empty active half, therefore yield o_read_ready=1 on the next cycle with no bubble.
- Read:
  - If i_read_en[i]=1 and o_read_ready[i]=1, read {active_sel, addr}. active_sel is captured at issue, so a read issued in the release cycle returns old-half data.
  - If o_read_ready[i]=0, the read is not issued and o_error[1] is set.
  - o_read_data_valid rises exactly READ_LATENCY cycles after issue. Fully pipelined: one read per cycle per array.
  - o_read_data holds its last value while valid is low.
- Simultaneous write to and read of the same half is impossible by construction.
- o_error: i_error_clear has priority over a new error set in the same cycle.
- Reset mid-operation: in-flight reads are discarded (valid pipeline cleared). Committed data becomes unreachable until rewritten.

Decomposition:
- Package weight_buffer_pkg: parameter defaults, error-bit index localparams (ERR_WRITE_FULL=0, ERR_READ_NOT_READY=1, ERR_COMMIT_FULL=2), address/row-word typedefs.
- Sub-module weight_pingpong_ctrl, instantiated per array: holds active_sel, active_valid and shadow_full, and generates ready flags, the physical address msb and error pulses.
- Storage: existing banked_line_buffer, at depth 2*BANK_DEPTH, with full-width data.

Test Plan:
- Reset, then commit to array 0 without writes -> cycle+1 o_read_ready[0]=1, o_write_ready[0]=1 (swap emptied shadow), active_sel=1.
- Write 0xA5.. at addr 7 (mask=3'b001, wen=16'hFFFF), commit, then read addr 7 with READ_LATENCY=2 -> o_read_data_valid[0] exactly 2 cycles later with 0xA5..; repeat with READ_LATENCY=1 -> 1 cycle.
- Fill and commit the shadow of array 1 while reading active; pulse release and read in the same cycle -> that read returns old data, the next cycle reads new data, and o_read_ready stays 1 (no bubble).
- Commit twice with no release -> o_error[2]=1; the write then dropped -> o_error[0]=1, memory unchanged; i_error_clear -> o_error=0.
- Read array 2 before any commit -> no valid pulse, o_error[1]=1.
- Issue reads back-to-back, assert reset mid-burst -> o_read_data_valid=0 on the next cycle, o_read_ready=0, o_write_ready=3'b111.

Source files
------------

// File: rtl/weight_buffer_pkg.sv
// Shared defaults, error-bit indices and types for the ping-pong weight row buffer.
package weight_buffer_pkg;

  localparam int DEF_BANK_BIT_WIDTH = 64;
  localparam int DEF_BANK_DEPTH     = 512;
  localparam int DEF_BANK_COUNT     = 16;
  localparam int DEF_ARRAYS         = 3;
  localparam int DEF_READ_LATENCY   = 2;

  localparam int ERR_WRITE_FULL     = 0;
  localparam int ERR_READ_NOT_READY = 1;
  localparam int ERR_COMMIT_FULL    = 2;
  localparam int ERR_WIDTH          = 3;

  localparam int DEF_ADDR_WIDTH = $clog2(DEF_BANK_DEPTH);

  typedef logic [DEF_ADDR_WIDTH-1:0]                      addr_t;
  typedef logic [DEF_BANK_BIT_WIDTH*DEF_BANK_COUNT-1:0]   row_word_t;
  typedef logic [ERR_WIDTH-1:0]                           err_vec_t;

  typedef struct packed {
    logic active_sel;
    logic active_valid;
    logic shadow_full;
  } pp_state_t;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/banked_line_buffer.sv
// Banked row memory with per-bank write enables and a 1- or 2-cycle read pipeline.
// Read data holds its last value while valid is low; contents are not reset.
module banked_line_buffer
  import weight_buffer_pkg::*;
#(
  parameter int BANK_BIT_WIDTH = DEF_BANK_BIT_WIDTH,
  parameter int DEPTH          = 2 * DEF_BANK_DEPTH,
  parameter int BANK_COUNT     = DEF_BANK_COUNT,
  parameter int READ_LATENCY   = DEF_READ_LATENCY,
  localparam int AW            = addr_width(DEPTH),
  localparam int RW            = BANK_BIT_WIDTH * BANK_COUNT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_en,
  input  logic [BANK_COUNT-1:0] write_bank_wen,
  input  logic [AW-1:0]         write_addr,
  input  logic [RW-1:0]         write_data,
  input  logic                  read_en,
  input  logic [AW-1:0]         read_addr,
  output logic                  read_data_valid,
  output logic [RW-1:0]         read_data
);

  logic [RW-1:0] rd_word;

  for (genvar b = 0; b < BANK_COUNT; b++) begin : g_bank
    logic [BANK_BIT_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (write_en && write_bank_wen[b]) begin
        mem[write_addr] <= write_data[b*BANK_BIT_WIDTH +: BANK_BIT_WIDTH];
      end
    end

    assign rd_word[b*BANK_BIT_WIDTH +: BANK_BIT_WIDTH] = mem[read_addr];
  end

  if (READ_LATENCY == 1) begin : g_lat1
    always_ff @(posedge clk) begin
      if (reset) begin
        read_data_valid <= 1'b0;
        read_data       <= '0;
      end else begin
        read_data_valid <= read_en;
        if (read_en) begin
          read_data <= rd_word;
        end
      end
    end
  end else begin : g_lat2
    logic          s1_valid;
    logic [RW-1:0] s1_data;

    // Stage-1 data needs no reset; only the valid bit gates it forward.
    always_ff @(posedge clk) begin
      if (read_en) begin
        s1_data <= rd_word;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        s1_valid        <= 1'b0;
        read_data_valid <= 1'b0;
        read_data       <= '0;
      end else begin
        s1_valid        <= read_en;
        read_data_valid <= s1_valid;
        if (s1_valid) begin
          read_data <= s1_data;
        end
      end
    end
  end

endmodule

// File: rtl/weight_pingpong_ctrl.sv
// Per-array ping-pong bookkeeping: which half is active, whether it is valid,
// whether the shadow half is committed, plus ready flags and error pulses.
//
//   flag         | meaning
//   active_sel   | physical half the consumer reads; the bus writes the other one
//   active_valid | active half holds committed data not yet released
//   shadow_full  | shadow half committed, waiting for the active half to drain
module weight_pingpong_ctrl
  import weight_buffer_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic write_req,
  input  logic commit,
  input  logic rel,
  input  logic read_req,
  output logic write_ready,
  output logic read_ready,
  output logic write_do,
  output logic read_do,
  output logic write_msb,
  output logic read_msb,
  output logic err_write_full,
  output logic err_read_not_ready,
  output logic err_commit_full
);

  pp_state_t st_q;
  pp_state_t st_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q <= '0;
    end else begin
      st_q <= st_d;
    end
  end

  always_comb begin
    st_d              = st_q;
    st_d.active_valid = st_q.active_valid & ~rel;
    st_d.shadow_full  = st_q.shadow_full | commit;
    // Swap on post-event values so release+commit in one cycle leaves no bubble.
    if (!st_d.active_valid && st_d.shadow_full) begin
      st_d.active_sel   = ~st_q.active_sel;
      st_d.active_valid = 1'b1;
      st_d.shadow_full  = 1'b0;
    end

    write_ready        = ~st_q.shadow_full;
    read_ready         = st_q.active_valid;
    write_do           = write_req & ~st_q.shadow_full;
    read_do            = read_req & st_q.active_valid;
    write_msb          = ~st_q.active_sel;
    read_msb           = st_q.active_sel;
    err_write_full     = write_req & st_q.shadow_full;
    err_read_not_ready = read_req & ~st_q.active_valid;
    err_commit_full    = commit & st_q.shadow_full;
  end

endmodule

// File: rtl/weight_row_pingpong_buffer.sv
// Double-buffered banked weight rows, one ping-pong pair per PE array: the bus
// fills the shadow half while the array reads the active half.
module weight_row_pingpong_buffer
  import weight_buffer_pkg::*;
#(
  parameter int BANK_BIT_WIDTH              = DEF_BANK_BIT_WIDTH,
  parameter int BANK_DEPTH                  = DEF_BANK_DEPTH,
  parameter int BANK_COUNT                  = DEF_BANK_COUNT,
  parameter int NUMBER_OF_PE_ARRAYS_PER_ROW = DEF_ARRAYS,
  parameter int READ_LATENCY                = DEF_READ_LATENCY,
  localparam int N  = NUMBER_OF_PE_ARRAYS_PER_ROW,
  localparam int AW = addr_width(BANK_DEPTH),
  localparam int RW = BANK_BIT_WIDTH * BANK_COUNT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N-1:0]          i_write_array_mask,
  input  logic                  i_write_en,
  input  logic [BANK_COUNT-1:0] i_write_bank_wen,
  input  logic [AW-1:0]         i_write_addr,
  input  logic [RW-1:0]         i_write_data,
  input  logic                  i_write_commit,
  output logic [N-1:0]          o_write_ready,
  input  logic [N-1:0]          i_read_en,
  input  logic [AW-1:0]         i_read_addr [N],
  input  logic [N-1:0]          i_read_release,
  output logic [N-1:0]          o_read_ready,
  output logic [N-1:0]          o_read_data_valid,
  output logic [RW-1:0]         o_read_data [N],
  output logic [ERR_WIDTH-1:0]  o_error,
  input  logic                  i_error_clear
);

  logic           write_req_any;
  logic [N-1:0]   err_wf;
  logic [N-1:0]   err_rnr;
  logic [N-1:0]   err_cf;
  err_vec_t       err_set;

  // A write with no enabled bank never touches memory and never flags an error.
  assign write_req_any = i_write_en & (|i_write_bank_wen);

  for (genvar g = 0; g < N; g++) begin : g_array
    logic write_do;
    logic read_do;
    logic write_msb;
    logic read_msb;

    weight_pingpong_ctrl u_ctrl (
      .clk                (clk),
      .reset              (reset),
      .write_req          (write_req_any & i_write_array_mask[g]),
      .commit             (i_write_commit & i_write_array_mask[g]),
      .rel                (i_read_release[g]),
      .read_req           (i_read_en[g]),
      .write_ready        (o_write_ready[g]),
      .read_ready         (o_read_ready[g]),
      .write_do           (write_do),
      .read_do            (read_do),
      .write_msb          (write_msb),
      .read_msb           (read_msb),
      .err_write_full     (err_wf[g]),
      .err_read_not_ready (err_rnr[g]),
      .err_commit_full    (err_cf[g])
    );

    banked_line_buffer #(
      .BANK_BIT_WIDTH (BANK_BIT_WIDTH),
      .DEPTH          (2 * BANK_DEPTH),
      .BANK_COUNT     (BANK_COUNT),
      .READ_LATENCY   (READ_LATENCY)
    ) u_mem (
      .clk             (clk),
      .reset           (reset),
      .write_en        (write_do),
      .write_bank_wen  (i_write_bank_wen),
      .write_addr      ({write_msb, i_write_addr}),
      .write_data      (i_write_data),
      .read_en         (read_do),
      .read_addr       ({read_msb, i_read_addr[g]}),
      .read_data_valid (o_read_data_valid[g]),
      .read_data       (o_read_data[g])
    );
  end

  always_comb begin
    err_set                     = '0;
    err_set[ERR_WRITE_FULL]     = |err_wf;
    err_set[ERR_READ_NOT_READY] = |err_rnr;
    err_set[ERR_COMMIT_FULL]    = |err_cf;
  end

  // Clear wins over a fresh error in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_error <= '0;
    end else if (i_error_clear) begin
      o_error <= '0;
    end else begin
      o_error <= o_error | err_set;
    end
  end

endmodule

// File: tb/tb_weight_row_pingpong_buffer.sv
// Bench for weight_row_pingpong_buffer: directed scenarios plus a randomized run,
// checked against a half/queue-level reference model, for READ_LATENCY 1 and 2.
module tb_weight_row_pingpong_buffer;

  localparam int W  = 64;
  localparam int D  = 512;
  localparam int BC = 16;
  localparam int N  = 3;
  localparam int AW = 9;
  localparam int RW = W * BC;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  wmask;
  logic          wen;
  logic [BC-1:0] bank_wen;
  logic [AW-1:0] waddr;
  logic [RW-1:0] wdata;
  logic          commit;
  logic [N-1:0]  rd_en;
  logic [AW-1:0] raddr [N];
  logic [N-1:0]  rel;
  logic          clr;

  logic [N-1:0]  wready1, wready2, rready1, rready2, valid1, valid2;
  logic [RW-1:0] rdata1 [N];
  logic [RW-1:0] rdata2 [N];
  logic [2:0]    err1, err2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  weight_row_pingpong_buffer #(.READ_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .i_write_array_mask(wmask), .i_write_en(wen),
    .i_write_bank_wen(bank_wen), .i_write_addr(waddr), .i_write_data(wdata),
    .i_write_commit(commit), .o_write_ready(wready1), .i_read_en(rd_en),
    .i_read_addr(raddr), .i_read_release(rel), .o_read_ready(rready1),
    .o_read_data_valid(valid1), .o_read_data(rdata1), .o_error(err1),
    .i_error_clear(clr));

  weight_row_pingpong_buffer #(.READ_LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .i_write_array_mask(wmask), .i_write_en(wen),
    .i_write_bank_wen(bank_wen), .i_write_addr(waddr), .i_write_data(wdata),
    .i_write_commit(commit), .o_write_ready(wready2), .i_read_en(rd_en),
    .i_read_addr(raddr), .i_read_release(rel), .o_read_ready(rready2),
    .o_read_data_valid(valid2), .o_read_data(rdata2), .o_error(err2),
    .i_error_clear(clr));

  // Reference model: contents of each (array, half) kept in an associative array,
  // read results delivered through explicit per-latency delay slots.
  logic [RW-1:0] mmem [int];
  logic [BC-1:0] mwritten [int];
  logic [N-1:0]  m_sel, m_av, m_sf;
  logic [2:0]    m_err;
  logic [N-1:0]  e_v1, e_v2, e_k1, e_k2, st_v, st_k;
  logic [RW-1:0] e_d1 [N];
  logic [RW-1:0] e_d2 [N];
  logic [RW-1:0] st_d [N];
  logic [2:0]    es;
  logic          c_av, c_sf, issue;
  logic [RW-1:0] rword, row;
  logic [BC-1:0] rmask;
  int            k;

  function automatic int mkey(input int a, input logic h, input logic [AW-1:0] ad);
    return (a * 2 + int'(h)) * D + int'(ad);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_sel = '0; m_av = '0; m_sf = '0; m_err = '0;
      e_v1 = '0; e_v2 = '0; st_v = '0; e_k1 = '1; e_k2 = '1; st_k = '0;
      for (int a = 0; a < N; a++) begin
        e_d1[a] = '0; e_d2[a] = '0;
      end
    end else begin
      es = '0;
      for (int a = 0; a < N; a++) begin
        issue = rd_en[a] && m_av[a];
        if (rd_en[a] && !m_av[a]) es[1] = 1'b1;
        k = mkey(a, m_sel[a], raddr[a]);
        rword = mmem.exists(k) ? mmem[k] : '0;
        rmask = mwritten.exists(k) ? mwritten[k] : '0;
        if (wen && wmask[a] && (bank_wen != '0)) begin
          if (m_sf[a]) es[0] = 1'b1;
          else begin
            k = mkey(a, !m_sel[a], waddr);
            row = mmem.exists(k) ? mmem[k] : '0;
            if (!mwritten.exists(k)) mwritten[k] = '0;
            for (int b = 0; b < BC; b++)
              if (bank_wen[b]) begin
                row[b*W +: W] = wdata[b*W +: W];
                mwritten[k][b] = 1'b1;
              end
            mmem[k] = row;
          end
        end
        c_sf = m_sf[a];
        if (commit && wmask[a]) begin
          if (m_sf[a]) es[2] = 1'b1;
          else c_sf = 1'b1;
        end
        c_av = m_av[a] && !rel[a];
        if (!c_av && c_sf) begin
          m_sel[a] = !m_sel[a]; c_av = 1'b1; c_sf = 1'b0;
        end
        m_av[a] = c_av; m_sf[a] = c_sf;
        e_v1[a] = issue;
        if (issue) begin e_d1[a] = rword; e_k1[a] = &rmask; end
        e_v2[a] = st_v[a];
        if (st_v[a]) begin e_d2[a] = st_d[a]; e_k2[a] = st_k[a]; end
        st_v[a] = issue; st_d[a] = rword; st_k[a] = &rmask;
      end
      if (clr) m_err = '0;
      else m_err = m_err | es;
    end
  end

  function automatic logic [RW-1:0] rand_row();
    logic [RW-1:0] r;
    for (int i = 0; i < RW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic idle();
    wmask = '0; wen = 1'b0; bank_wen = '0; waddr = '0; wdata = '0; commit = 1'b0;
    rd_en = '0; rel = '0; clr = 1'b0;
    for (int a = 0; a < N; a++) raddr[a] = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_row(input logic [N-1:0] m, input logic [AW-1:0] ad, input logic [RW-1:0] d);
    wmask = m; wen = 1'b1; bank_wen = '1; waddr = ad; wdata = d;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tests++; if (rready1 !== 3'b000 || rready2 !== 3'b000) begin fails++; $display("FAIL reset_rready got=%b/%b exp=000", rready1, rready2); end
    tests++; if (wready1 !== 3'b111 || wready2 !== 3'b111) begin fails++; $display("FAIL reset_wready got=%b/%b exp=111", wready1, wready2); end
    tests++; if (valid1 !== 3'b000 || valid2 !== 3'b000 || err1 !== 3'b000 || err2 !== 3'b000) begin fails++; $display("FAIL reset_valid_err got=%b %b %b %b exp=0", valid1, valid2, err1, err2); end
    tests++; if (rdata1[0] !== '0 || rdata2[2] !== '0) begin fails++; $display("FAIL reset_data got nonzero exp=0"); end
  endtask

  task automatic test_commit_empty();
    wmask = 3'b001; commit = 1'b1;
    tick();
    idle();
    tests++; if (rready1[0] !== 1'b1 || rready2[0] !== 1'b1) begin fails++; $display("FAIL commit_empty_rready got=%b/%b exp=1", rready1[0], rready2[0]); end
    tests++; if (wready1[0] !== 1'b1 || wready2[0] !== 1'b1) begin fails++; $display("FAIL commit_empty_wready got=%b/%b exp=1", wready1[0], wready2[0]); end
    tests++; if (m_sel[0] !== 1'b1) begin fails++; $display("FAIL commit_empty_sel got=%b exp=1", m_sel[0]); end
  endtask

  task automatic test_read_latency();
    logic [RW-1:0] r;
    r = {(RW / 8){8'hA5}};
    write_row(3'b001, 9'd7, r);
    wmask = 3'b001; commit = 1'b1; rel = 3'b001;
    tick();
    idle();
    tests++; if (rready1[0] !== 1'b1 || rready2[0] !== 1'b1) begin fails++; $display("FAIL lat_swap_rready got=%b/%b exp=1", rready1[0], rready2[0]); end
    rd_en = 3'b001; raddr[0] = 9'd7;
    tick();
    idle();
    tests++; if (valid1[0] !== 1'b1 || rdata1[0] !== r) begin fails++; $display("FAIL lat1_data got v=%b d=%h exp v=1 d=%h", valid1[0], rdata1[0], r); end
    tests++; if (valid2[0] !== 1'b0) begin fails++; $display("FAIL lat2_early got=%b exp=0", valid2[0]); end
    tick();
    tests++; if (valid2[0] !== 1'b1 || rdata2[0] !== r) begin fails++; $display("FAIL lat2_data got v=%b d=%h exp v=1 d=%h", valid2[0], rdata2[0], r); end
    tests++; if (valid1[0] !== 1'b0 || rdata1[0] !== r) begin fails++; $display("FAIL lat1_hold got v=%b d=%h exp v=0 d=%h", valid1[0], rdata1[0], r); end
  endtask

  task automatic test_release_swap();
    logic [RW-1:0] r_old, r_new;
    r_old = rand_row(); r_new = rand_row();
    write_row(3'b010, 9'd3, r_old);
    wmask = 3'b010; commit = 1'b1; tick(); idle();
    write_row(3'b010, 9'd3, r_new);
    wmask = 3'b010; commit = 1'b1; tick(); idle();
    tests++; if (wready1[1] !== 1'b0) begin fails++; $display("FAIL swap_shadow_full got=%b exp=0", wready1[1]); end
    rel = 3'b010; rd_en = 3'b010; raddr[1] = 9'd3;
    tick();
    rel = '0;
    tests++; if (rready1[1] !== 1'b1 || rready2[1] !== 1'b1) begin fails++; $display("FAIL swap_no_bubble got=%b/%b exp=1", rready1[1], rready2[1]); end
    tests++; if (rdata1[1] !== r_old) begin fails++; $display("FAIL swap_old_data got=%h exp=%h", rdata1[1], r_old); end
    tick();
    idle();
    tests++; if (rdata1[1] !== r_new || rdata2[1] !== r_old) begin fails++; $display("FAIL swap_new_data got=%h exp=%h", rdata1[1], r_new); end
    tick();
    tests++; if (rdata2[1] !== r_new || valid2[1] !== 1'b1) begin fails++; $display("FAIL swap_new_data_l2 got=%h exp=%h", rdata2[1], r_new); end
    tests++; if (err1 !== 3'b000 || err2 !== 3'b000) begin fails++; $display("FAIL swap_no_error got=%b/%b exp=000", err1, err2); end
  endtask

  task automatic test_errors();
    logic [RW-1:0] ra, rb;
    ra = rand_row(); rb = rand_row();
    write_row(3'b001, 9'd9, ra);
    wmask = 3'b001; commit = 1'b1; tick(); idle();
    wmask = 3'b001; commit = 1'b1; tick(); idle();
    tests++; if (err1 !== 3'b100 || err2 !== 3'b100) begin fails++; $display("FAIL err_commit_full got=%b/%b exp=100", err1, err2); end
    write_row(3'b001, 9'd9, rb);
    tests++; if (err1 !== 3'b101 || err2 !== 3'b101) begin fails++; $display("FAIL err_write_full got=%b/%b exp=101", err1, err2); end
    rel = 3'b001; tick(); idle();
    rd_en = 3'b001; raddr[0] = 9'd9; tick(); idle();
    tests++; if (rdata1[0] !== ra) begin fails++; $display("FAIL err_mem_unchanged got=%h exp=%h", rdata1[0], ra); end
    wmask = 3'b001; wen = 1'b1; bank_wen = '0; tick(); idle();
    tests++; if (err1 !== 3'b101) begin fails++; $display("FAIL err_wen0_noop got=%b exp=101", err1); end
    clr = 1'b1; rd_en = 3'b100; tick(); idle();
    tests++; if (err1 !== 3'b000 || err2 !== 3'b000) begin fails++; $display("FAIL err_clear_priority got=%b/%b exp=000", err1, err2); end
  endtask

  task automatic test_read_not_ready();
    logic [N-1:0] seen;
    seen = '0;
    rd_en = 3'b100; raddr[2] = 9'd1;
    tick();
    idle();
    for (int c = 0; c < 3; c++) begin
      seen = seen | valid1 | valid2;
      tick();
    end
    tests++; if (seen[2] !== 1'b0) begin fails++; $display("FAIL rnr_no_valid got=%b exp=0", seen[2]); end
    tests++; if (err1 !== 3'b010 || err2 !== 3'b010) begin fails++; $display("FAIL rnr_error got=%b/%b exp=010", err1, err2); end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      wmask = 3'($urandom_range(0, 7));
      wen = ($urandom_range(0, 3) != 0);
      bank_wen = ($urandom_range(0, 3) == 0) ? 16'($urandom) : '1;
      waddr = 9'($urandom_range(0, 15));
      wdata = rand_row();
      commit = ($urandom_range(0, 5) == 0);
      rd_en = 3'($urandom);
      for (int a = 0; a < N; a++) begin
        raddr[a] = 9'($urandom_range(0, 15));
        rel[a] = ($urandom_range(0, 5) == 0);
      end
      clr = ($urandom_range(0, 15) == 0);
      tick();
      tests++; if (rready1 !== m_av || rready2 !== m_av) begin fails++; $display("FAIL rnd_rready cyc=%0d got=%b/%b exp=%b", cyc, rready1, rready2, m_av); end
      tests++; if (wready1 !== ~m_sf || wready2 !== ~m_sf) begin fails++; $display("FAIL rnd_wready cyc=%0d got=%b/%b exp=%b", cyc, wready1, wready2, ~m_sf); end
      tests++; if (err1 !== m_err || err2 !== m_err) begin fails++; $display("FAIL rnd_error cyc=%0d got=%b/%b exp=%b", cyc, err1, err2, m_err); end
      tests++; if (valid1 !== e_v1 || valid2 !== e_v2) begin fails++; $display("FAIL rnd_valid cyc=%0d got=%b/%b exp=%b/%b", cyc, valid1, valid2, e_v1, e_v2); end
      for (int a = 0; a < N; a++) begin
        if (e_k1[a]) begin
          tests++; if (rdata1[a] !== e_d1[a]) begin fails++; $display("FAIL rnd_data_l1 cyc=%0d arr=%0d got=%h exp=%h", cyc, a, rdata1[a], e_d1[a]); end
        end
        if (e_k2[a]) begin
          tests++; if (rdata2[a] !== e_d2[a]) begin fails++; $display("FAIL rnd_data_l2 cyc=%0d arr=%0d got=%h exp=%h", cyc, a, rdata2[a], e_d2[a]); end
        end
      end
    end
    idle();
  endtask

  task automatic test_reset_midburst();
    reset = 1'b1; tick(); reset = 1'b0;
    wmask = 3'b111; commit = 1'b1; tick(); idle();
    rd_en = 3'b111;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    tests++; if (valid1 !== 3'b000 || valid2 !== 3'b000) begin fails++; $display("FAIL midrst_valid got=%b/%b exp=000", valid1, valid2); end
    tests++; if (rready1 !== 3'b000 || wready1 !== 3'b111 || rready2 !== 3'b000 || wready2 !== 3'b111) begin fails++; $display("FAIL midrst_ready got r=%b w=%b exp r=000 w=111", rready1, wready1); end
    reset = 1'b0; idle();
    tick();
    tests++; if (valid2 !== 3'b000 || err1 !== 3'b000) begin fails++; $display("FAIL midrst_flushed got v=%b e=%b exp 0", valid2, err1); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    reset = 1'b1;
    test_reset();
    test_commit_empty();
    test_read_latency();
    test_release_swap();
    test_errors();
    test_read_not_ready();
    test_random();
    test_reset_midburst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
